// File: rtl/readout_if.sv
// readout_if: timing strobes into the readout generator, VRAM fetch address and cell position out.
interface readout_if #(
  parameter int ADDR_W = 13,
  parameter int ROW_W = 4,
  parameter int CNT_W = 3,
  parameter int PH_W = 1
);
  logic vActive;
  logic hBeginActive;
  logic hEndActive;
  logic hBeginPulse;
  logic [ROW_W-1:0] vCount;
  logic vSync;
  logic [ADDR_W-1:0] baseAddr;
  logic [ADDR_W-1:0] readoutAddr;
  logic [CNT_W-1:0] readoutCount;
  logic [PH_W-1:0] phase;
  logic active;
  modport master (
    input vActive, hBeginActive, hEndActive, hBeginPulse, vCount, vSync, baseAddr,
    output readoutAddr, readoutCount, phase, active
  );
  modport slave (
    output vActive, hBeginActive, hEndActive, hBeginPulse, vCount, vSync, baseAddr,
    input readoutAddr, readoutCount, phase, active
  );
endinterface

// File: rtl/readout_gen.sv
// readout_gen: per-scanline VRAM fetch address generator with row repeat and address wrap.
// Optional scroll base address enabled by defining READOUT_SCROLL_EN.
module readout_gen #(
  parameter int ADDR_W = 13,
  parameter int VRAM_DEPTH = 8192,
  parameter int FETCHES = 2,
  parameter int SLOT_CYCLES = 4,
  parameter int START_COUNT = 2,
  parameter int CHAR_H = 16,
  parameter int ROW_W = 4
) (
  input logic clk,
  input logic nrst,
  readout_if.master bus
);
  localparam int CNT_W = $clog2(FETCHES * SLOT_CYCLES);
  localparam int PH_W = (FETCHES > 1) ? $clog2(FETCHES) : 1;
  localparam int SC_W = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FETCHES * SLOT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(VRAM_DEPTH);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CHAR_H - 1);
  logic [ADDR_W-1:0] rowBegin;
  logic [ADDR_W-1:0] frameBase;
  logic [ADDR_W-1:0] nextAddr;
  logic [CNT_W-1:0] nextCount;
  logic slotStart;
`ifdef READOUT_SCROLL_EN
  assign frameBase = ({1'b0, bus.baseAddr} < DEPTH) ? bus.baseAddr : '0;
`else
  logic unusedBase;
  assign unusedBase = ^{bus.baseAddr, DEPTH};
  assign frameBase = '0;
`endif
  assign nextAddr = (bus.readoutAddr == LAST_ADDR) ? '0 : bus.readoutAddr + 1'b1;
  assign nextCount = (bus.readoutCount == LAST_CNT) ? '0 : bus.readoutCount + 1'b1;
  assign slotStart = bus.readoutCount[SC_W-1:0] == '0;
  assign bus.phase = PH_W'(bus.readoutCount >> SC_W);
  // vSync outranks everything but reset; the count deliberately holds through it
  always_ff @(posedge clk) begin
    if (!nrst) begin
      bus.active <= 1'b0;
      bus.readoutCount <= '0;
      bus.readoutAddr <= '0;
      rowBegin <= '0;
    end else if (!bus.vSync) begin
      bus.active <= 1'b0;
      bus.readoutAddr <= frameBase;
      rowBegin <= frameBase;
    end else if (bus.active) begin
      bus.readoutCount <= nextCount;
      if (slotStart) bus.readoutAddr <= nextAddr;
      if (bus.hEndActive) bus.active <= 1'b0;
    end else if (bus.vActive) begin
      if (bus.hBeginActive) begin
        bus.active <= 1'b1;
        bus.readoutCount <= CNT_W'(START_COUNT);
      end
      if (bus.hBeginPulse) begin
        if (bus.vCount == LAST_ROW) rowBegin <= bus.readoutAddr;
        else bus.readoutAddr <= rowBegin;
      end
    end
  end
endmodule

// File: tb/tb_readout_gen.sv
// tb_readout_gen: scoreboard bench; dut1 uses defaults, dut2 uses CHAR_H=12 and VRAM_DEPTH=40.
module tb_readout_gen;
  typedef struct packed {
    logic [12:0] addr;
    logic [2:0] cnt;
    logic act;
    logic ph;
  } obs_t;
  logic clk = 0;
  logic nrst = 0;
  logic vActive = 0, hBeginActive = 0, hEndActive = 0, hBeginPulse = 0, vSync = 1, sel = 0;
  logic [3:0] vCount = 0;
  logic [12:0] baseAddr = 0;
  obs_t q[$];
  obs_t obs, e;
  int nTests = 0, nFail = 0;
  readout_if bus1();
  readout_if bus2();
  readout_gen dut1 (.clk(clk), .nrst(nrst), .bus(bus1));
  readout_gen #(.VRAM_DEPTH(40), .CHAR_H(12)) dut2 (.clk(clk), .nrst(nrst), .bus(bus2));
  always #5 clk = ~clk;
  // sel steers the strobes to one instance and picks which outputs are observed
  assign bus1.vActive = vActive;
  assign bus2.vActive = vActive;
  assign bus1.vCount = vCount;
  assign bus2.vCount = vCount;
  assign bus1.baseAddr = baseAddr;
  assign bus2.baseAddr = baseAddr;
  assign bus1.hBeginActive = hBeginActive & ~sel;
  assign bus2.hBeginActive = hBeginActive & sel;
  assign bus1.hEndActive = hEndActive & ~sel;
  assign bus2.hEndActive = hEndActive & sel;
  assign bus1.hBeginPulse = hBeginPulse & ~sel;
  assign bus2.hBeginPulse = hBeginPulse & sel;
  assign bus1.vSync = vSync | sel;
  assign bus2.vSync = vSync | ~sel;
  assign obs = sel ? {bus2.readoutAddr, bus2.readoutCount, bus2.active, bus2.phase}
                   : {bus1.readoutAddr, bus1.readoutCount, bus1.active, bus1.phase};

  task automatic test_reset();
    nrst = 0;
    for (int c = 0; c < 2; c++) begin
      {vActive, hBeginActive, hEndActive, hBeginPulse, vSync} = 5'($urandom);
      vCount = 4'($urandom);
      baseAddr = 13'($urandom);
      @(posedge clk); #1;
    end
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      q.push_back('0);
      @(negedge clk);
      e = q.pop_front();
      nTests++;
      if (obs !== e) begin
        nFail++;
        $display("FAIL reset dut%0d: addr=%0d cnt=%0d act=%b ph=%b, want all zero", s + 1, obs.addr, obs.cnt, obs.act, obs.ph);
      end
    end
    sel = 0;
    {vActive, hBeginActive, hEndActive, hBeginPulse} = '0;
    vSync = 1;
    vCount = 0;
    baseAddr = 0;
    nrst = 1;
  endtask

  task automatic test_line(input int base, input int len, input int depth);
    @(posedge clk); #1;
    vActive = 1;
    hBeginActive = 1;
    @(posedge clk); #1;
    hBeginActive = 0;
    for (int i = 1; i <= len; i++) begin
      hEndActive = (i == len);
      e = '{addr: 13'((base + i / 4) % depth), cnt: 3'((i + 1) % 8), act: 1'b1, ph: 1'(((i + 1) % 8) / 4)};
      q.push_back(e);
      @(negedge clk);
      e = q.pop_front();
      nTests++;
      if (obs !== e) begin
        nFail++;
        $display("FAIL line cycle %0d: addr=%0d cnt=%0d act=%b ph=%b, want addr=%0d cnt=%0d act=%b ph=%b",
                 i, obs.addr, obs.cnt, obs.act, obs.ph, e.addr, e.cnt, e.act, e.ph);
      end
      @(posedge clk); #1;
    end
    hEndActive = 0;
    e = '{addr: 13'((base + len / 4) % depth), cnt: 3'((len + 2) % 8), act: 1'b0, ph: 1'(((len + 2) % 8) / 4)};
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    nTests++;
    if (obs !== e) begin
      nFail++;
      $display("FAIL line end: addr=%0d cnt=%0d act=%b, want addr=%0d cnt=%0d act=%b", obs.addr, obs.cnt, obs.act, e.addr, e.cnt, e.act);
    end
  endtask

  task automatic test_row_pulse(input int row, input int expAddr);
    @(posedge clk); #1;
    vActive = 1;
    vCount = 4'(row);
    hBeginPulse = 1;
    q.push_back('{addr: 13'(expAddr), cnt: 3'd2, act: 1'b0, ph: 1'b0});
    @(posedge clk); #1;
    hBeginPulse = 0;
    @(negedge clk);
    e = q.pop_front();
    nTests++;
    if (obs !== e) begin
      nFail++;
      $display("FAIL row pulse vCount=%0d: addr=%0d cnt=%0d act=%b, want addr=%0d cnt=%0d act=%b", row, obs.addr, obs.cnt, obs.act, e.addr, e.cnt, e.act);
    end
  endtask

  task automatic test_vsync();
`ifdef READOUT_SCROLL_EN
    int fb = 160;
`else
    int fb = 0;
`endif
    baseAddr = 13'h0A0;
    @(posedge clk); #1;
    vActive = 1;
    hBeginActive = 1;
    @(posedge clk); #1;
    hBeginActive = 0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    vSync = 0;
    for (int k = 0; k < 3; k++) begin
      q.push_back('{addr: 13'(fb), cnt: 3'd4, act: 1'b0, ph: 1'b1});
      @(posedge clk); #1;
      hBeginActive = 1;
      @(negedge clk);
      e = q.pop_front();
      nTests++;
      if (obs !== e) begin
        nFail++;
        $display("FAIL vsync cycle %0d: addr=%0d cnt=%0d act=%b, want addr=%0d cnt=%0d act=%b", k, obs.addr, obs.cnt, obs.act, e.addr, e.cnt, e.act);
      end
    end
    @(posedge clk); #1;
    vSync = 1;
    hBeginActive = 0;
    test_line(fb, 64, 8192);
`ifdef READOUT_SCROLL_EN
    baseAddr = 13'd8190;
    @(posedge clk); #1;
    vSync = 0;
    @(posedge clk); #1;
    vSync = 1;
    test_line(8190, 16, 8192);
`endif
    baseAddr = 0;
  endtask

  task automatic test_reset_midline();
    @(posedge clk); #1;
    vActive = 1;
    hBeginActive = 1;
    @(posedge clk); #1;
    hBeginActive = 0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    nrst = 0;
    q.push_back('0);
    @(posedge clk); #1;
    nrst = 1;
    @(negedge clk);
    e = q.pop_front();
    nTests++;
    if (obs !== e) begin
      nFail++;
      $display("FAIL midline reset: addr=%0d cnt=%0d act=%b ph=%b, want all zero", obs.addr, obs.cnt, obs.act, obs.ph);
    end
  endtask

  task automatic test_char_h12();
    sel = 1;
    test_line(0, 64, 40);
    test_row_pulse(11, 16);
    test_line(16, 64, 40);
    test_row_pulse(3, 16);
    test_line(16, 64, 40);
    test_row_pulse(15, 16);
    baseAddr = 13'd50;
    @(posedge clk); #1;
    vSync = 0;
    q.push_back('{addr: 13'd0, cnt: 3'd2, act: 1'b0, ph: 1'b0});
    @(posedge clk); #1;
    vSync = 1;
    @(negedge clk);
    e = q.pop_front();
    nTests++;
    if (obs !== e) begin
      nFail++;
      $display("FAIL dut2 oversize base: addr=%0d act=%b, want addr=%0d act=%b", obs.addr, obs.act, e.addr, e.act);
    end
    baseAddr = 0;
    test_line(0, 192, 40);
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_line(0, 640, 8192);
    test_row_pulse(3, 0);
    test_line(0, 640, 8192);
    test_row_pulse(15, 160);
    test_line(160, 640, 8192);
    test_row_pulse(3, 160);
    test_vsync();
    test_reset_midline();
    test_char_h12();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/readout_gen.md
# readout_gen

Parametrised VRAM readout address generator for the display controller. It produces the per-scanline sequence of VRAM fetch addresses for character/attribute data, repeating each character row for every pixel row and advancing to the next character row after the last one. Beyond the fixed 8-cycle, 2-fetch predecessor, it adds:
- a configurable fetch slot layout and character height;
- VRAM address wrap at a configurable depth;
- an optional hardware scroll base address.

It sits between the timing generator (sync/active strobes) and the VRAM read port and pixel generator.

## Interface
- ADDR_W, 13, VRAM address width
- VRAM_DEPTH, 8192, number of addressable words; addresses wrap modulo this (must be ≤ 2^ADDR_W)
- FETCHES, 2, fetch slots per character cell (slot 0 = character, 1 = attribute, ...)
- SLOT_CYCLES, 4, clocks per fetch slot (power of two ≥ 2)
- START_COUNT, 2, readoutCount load value at activity start
- CHAR_H, 16, pixel rows per character row
- ROW_W, 4, width of vCount (≥ clog2(CHAR_H))
- CNT_W = clog2(FETCHES*SLOT_CYCLES), PH_W = max(1, clog2(FETCHES)) (derived localparams)
- clk  in  1  pixel clock
- nrst  in  1  reset, synchronous, active-low
- vActive  in  1  vertical active region
- hBeginActive  in  1  one-cycle strobe: horizontal active region begins next cycle
- hEndActive  in  1  one-cycle strobe: last active cycle of scanline
- hBeginPulse  in  1  one-cycle strobe at hsync pulse start (outside active region)
- vCount  in  ROW_W  pixel row within current character row
- vSync  in  1  vertical sync, active-low
- baseAddr  in  ADDR_W  scroll base address (used only with READOUT_SCROLL_EN)
- readoutAddr  out  ADDR_W  VRAM read address
- readoutCount  out  CNT_W  cycle counter within character cell
- phase  out  PH_W  current fetch slot = readoutCount / SLOT_CYCLES
- active  out  1  readout activity in progress

## Operation
- State: active, readoutCount, readoutAddr, rowBegin. Priority per clock: nrst low > vSync low > normal.
- Reset: active=0, readoutCount=0, readoutAddr=0, rowBegin=0, phase=0.
- vSync low:
  - rowBegin and readoutAddr are loaded with the frame base (baseAddr with scroll enabled, else 0).
  - active is forced to 0; readoutCount holds.
- Idle (active=0):
  - hBeginActive & vActive: active←1, readoutCount←START_COUNT.
  - vActive & hBeginPulse & vCount==CHAR_H-1: rowBegin←readoutAddr (start next character row).
  - vActive & hBeginPulse & vCount≠CHAR_H-1: readoutAddr←rowBegin (repeat current character row).
  - Strobes without vActive are ignored.
- Active (active=1):
  - readoutCount←readoutCount+1, wrapping mod FETCHES*SLOT_CYCLES.
  - When readoutCount mod SLOT_CYCLES == 0, readoutAddr advances by 1. At VRAM_DEPTH-1 it wraps to 0.
  - hEndActive: active←0 next cycle; that cycle's count and address updates still occur.
  - hBeginActive and hBeginPulse are ignored while active.
- Arithmetic: all address math is modulo VRAM_DEPTH. A baseAddr ≥ VRAM_DEPTH loads 0.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- readoutAddr updated at edge N is valid to VRAM from cycle N+1. With default parameters, a new address is presented at readoutCount 1 and 5, one slot ahead of data use.
- active rises 1 cycle after hBeginActive and falls 1 cycle after hEndActive.
- Active for L cycles with START_COUNT=2 and defaults: address advances FETCHES×(L/8) when L is a multiple of 8.
- hBeginPulse row logic takes effect on the next edge. It must precede the following hBeginActive by ≥1 cycle; the timing generator guarantees this.
- Reset mid-line: outputs reach reset values on the next edge regardless of active.

## Configuration
- READOUT_SCROLL_EN defined: baseAddr is sampled on every vSync-low cycle; the last sampled value becomes the frame's start address, enabling vertical/horizontal scroll.
- READOUT_SCROLL_EN undefined: baseAddr is ignored (port kept, unused); the frame base is constant 0, matching the legacy behaviour.

## Test plan
- Reset: nrst=0 for 2 cycles with random inputs → readoutAddr=0, readoutCount=0, active=0, phase=0.
- Defaults, vActive=1, hBeginActive then 640 active cycles, hEndActive on the 640th → readoutAddr=160, active=0; phase toggles every 4 cycles.
- Row repeat: after the above, hBeginPulse with vCount=3 → readoutAddr=0. Repeat with vCount=15 → rowBegin=160, and the next line's first fetch address is 161.
- CHAR_H=12, ROW_W=4: hBeginPulse with vCount=11 advances the row; vCount=15 (out of range) repeats the row.
- Wrap (scroll enabled): baseAddr=8190, vSync low then line start → fetched addresses 8191, 0, 1, 2.
- Scroll disabled: baseAddr=0x0A0 during vSync → readoutAddr=0 after vSync. With READOUT_SCROLL_EN → readoutAddr=160 after vSync, active=0 throughout vSync.
